// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave with a word-organised memory and WAIT_STATES wait cycles per transfer.
// Define AHB_SLAVE_ERROR_EN to build the size/alignment/range ERROR response path.
module ahb_slave_mem #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic                  hsel,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [2:0]            hburst,
    input  logic [3:0]            hprot,
    input  logic [1:0]            htrans,
    input  logic                  hready,
    input  logic [DATA_WIDTH-1:0] hwdata,
    output logic                  hreadyout,
    output logic                  hresp,
    output logic [DATA_WIDTH-1:0] hrdata,
    output logic [2:0]            o_dbg_state
);
    localparam int IDX_W = $clog2(MEM_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_DATA = 3'd2
`ifdef AHB_SLAVE_ERROR_EN
        ,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
`endif
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [2:0]            r_wait_cnt;
    logic [IDX_W+1:0]      r_addr;
    logic                  r_write;
    logic [2:0]            r_size;
    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    logic                  w_open;
    logic                  w_accept;
    logic                  w_commit;
    logic [3:0]            w_lane_en;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_unused;

`ifdef AHB_SLAVE_ERROR_EN
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEM_DEPTH);
    logic w_err;

    assign w_err  = (hsize > 3'd2)
                 || (hsize == 3'd1 && haddr[0])
                 || (hsize == 3'd2 && haddr[1:0] != 2'b00)
                 || ((haddr >> 2) >= DEPTH_A);
    assign w_open = (r_state != S_WAIT) && (r_state != S_ERR1);
`else
    assign w_open = (r_state != S_WAIT);
`endif

    // The slave only samples an address phase while its own data phase is ready.
    assign w_accept = hsel & hready & htrans[1] & w_open;

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = S_IDLE;
        hreadyout = 1'b1;
        hresp     = 1'b0;
        case (r_state)
            S_WAIT: begin
                hreadyout = 1'b0;
                w_next    = (r_wait_cnt == 3'd1) ? S_DATA : S_WAIT;
            end
`ifdef AHB_SLAVE_ERROR_EN
            S_ERR1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
                w_next    = S_ERR2;
            end
            S_ERR2: begin
                hresp = 1'b1;
            end
`endif
            default: ;
        endcase
        if (w_accept) begin
`ifdef AHB_SLAVE_ERROR_EN
            if (w_err) begin
                w_next = S_ERR1;
            end else begin
                w_next = (WAIT_STATES > 0) ? S_WAIT : S_DATA;
            end
`else
            w_next = (WAIT_STATES > 0) ? S_WAIT : S_DATA;
`endif
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_wait_cnt <= 3'd0;
            r_addr     <= '0;
            r_write    <= 1'b0;
            r_size     <= 3'd0;
        end else begin
            if (w_accept) begin
                r_addr  <= haddr[IDX_W+1:0];
                r_write <= hwrite;
                r_size  <= hsize;
            end
            if (w_accept && w_next == S_WAIT) begin
                r_wait_cnt <= 3'(WAIT_STATES);
            end else if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt - 3'd1;
            end
        end
    end

    // Misaligned low bits fall away here: halfwords use addr[1] only, words every lane.
    always_comb begin
        case (r_size)
            3'd0:    w_lane_en = 4'b0001 << r_addr[1:0];
            3'd1:    w_lane_en = r_addr[1] ? 4'b1100 : 4'b0011;
            default: w_lane_en = 4'b1111;
        endcase
    end

    assign w_idx    = r_addr[IDX_W+1:2];
    assign w_commit = (r_state == S_DATA) && r_write;

    always_ff @(posedge hclk) begin
        if (w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (w_lane_en[i]) begin
                    r_mem[w_idx][8*i +: 8] <= hwdata[8*i +: 8];
                end
            end
        end
    end

    assign hrdata      = (r_state == S_DATA && !r_write) ? r_mem[w_idx] : '0;
    assign o_dbg_state = r_state;
    assign w_unused    = ^{hburst, hprot, htrans[0], haddr[ADDR_WIDTH-1:IDX_W+2]};
endmodule
